// File: rtl/raster_span_gen_pkg.sv
// Shared types for the span rasteriser: FSM state encoding and the per-edge coverage rule.
package raster_span_gen_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE  = 2'd0,
    GEN_SETUP = 2'd1,
    GEN_SCAN  = 2'd2
  } gen_state_t;

  // Zero lies on the edge: owned only by top-left edges when the tie-break rule is on.
  function automatic logic edge_inside(input logic neg, input logic zero,
                                       input logic tl, input logic top_left);
    if (neg) return 1'b0;
    if (!zero) return 1'b1;
    return top_left ? tl : 1'b1;
  endfunction

endpackage

// File: rtl/span_fifo.sv
// Generic synchronous FIFO, depth 2^LG_DEPTH, head visible combinationally while not empty.
// Pushes while full and pops while empty are dropped.
module span_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0] PTR_ONE = 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [LG_DEPTH:0] wr_ptr_q;
  logic [LG_DEPTH:0] rd_ptr_q;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[LG_DEPTH] != rd_ptr_q[LG_DEPTH]) &&
                 (wr_ptr_q[LG_DEPTH-1:0] == rd_ptr_q[LG_DEPTH-1:0]);
  assign head  = mem_q[rd_ptr_q[LG_DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[LG_DEPTH-1:0]] <= push_dat;
  end

endmodule

// File: rtl/raster_span_gen.sv
// Walks a triangle's bounding box LANES pixels per cycle and queues one coverage packet per span.
// A non-empty span waits while the output FIFO is full; skipped empty spans never stall.
module raster_span_gen
  import raster_span_gen_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned CW         = 16,
  parameter int unsigned EW         = 32,
  parameter int unsigned LG_DEPTH   = 3,
  parameter bit          SKIP_EMPTY = 1'b1,
  parameter bit          TOP_LEFT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    xmin,
  input  logic [CW-1:0]    xmax,
  input  logic [CW-1:0]    ymin,
  input  logic [CW-1:0]    ymax,
  input  logic [EW-1:0]    w0_00,
  input  logic [EW-1:0]    w1_00,
  input  logic [EW-1:0]    w2_00,
  input  logic [EW-1:0]    sx0,
  input  logic [EW-1:0]    sx1,
  input  logic [EW-1:0]    sx2,
  input  logic [EW-1:0]    sy0,
  input  logic [EW-1:0]    sy1,
  input  logic [EW-1:0]    sy2,
  input  logic [2:0]       tl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_x,
  output logic [CW-1:0]    out_y,
  output logic [LANES-1:0] out_mask,
  output logic [EW-1:0]    out_w0,
  output logic [EW-1:0]    out_w1,
  output logic [EW-1:0]    out_w2,
  output logic             busy,
  output logic             done,
  output logic             idle
);

  localparam int unsigned LG_LANES = $clog2(LANES);
  localparam int unsigned XW       = CW + 1;

  typedef struct packed {
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic [LANES-1:0] mask;
    logic [EW-1:0]    w0;
    logic [EW-1:0]    w1;
    logic [EW-1:0]    w2;
  } span_pkt_t;

  gen_state_t    state_q;
  logic          done_q;
  logic [CW-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [CW-1:0] x_q, y_q;
  logic [2:0]    tl_q;
  logic [EW-1:0] sx_q   [3];
  logic [EW-1:0] sy_q   [3];
  logic [EW-1:0] w_q    [3];
  logic [EW-1:0] rb_q   [3];
  logic [EW-1:0] step_q [3];
  logic [EW-1:0] off_q  [3][LANES];

  logic [EW-1:0] w00_in [3];
  logic [EW-1:0] sx_in  [3];
  logic [EW-1:0] sy_in  [3];

  assign w00_in[0] = w0_00;
  assign w00_in[1] = w1_00;
  assign w00_in[2] = w2_00;
  assign sx_in[0]  = sx0;
  assign sx_in[1]  = sx1;
  assign sx_in[2]  = sx2;
  assign sy_in[0]  = sy0;
  assign sy_in[1]  = sy1;
  assign sy_in[2]  = sy2;

  // Constant-k multiply by shift/add; k never exceeds 15.
  function automatic logic [EW-1:0] lane_mul(input logic [EW-1:0] s, input logic [4:0] k);
    logic [EW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 5; b++) begin
      if (k[b]) acc = acc + (s << b);
    end
    return acc;
  endfunction

  logic [LANES-1:0] span_mask;
  logic             lane_ok;
  logic [EW-1:0]    lane_w;

  always_comb begin
    span_mask = '0;
    lane_ok   = 1'b0;
    lane_w    = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_ok = ({1'b0, x_q} + XW'(k)) <= {1'b0, xmax_q};
      for (int i = 0; i < 3; i++) begin
        lane_w  = w_q[i] + off_q[i][k];
        lane_ok = lane_ok & edge_inside(lane_w[EW-1], lane_w == '0, tl_q[i], TOP_LEFT);
      end
      span_mask[k] = lane_ok;
    end
  end

  logic      fifo_full, fifo_empty;
  logic      in_scan, skip, push, dispose, more_x, last_row;
  span_pkt_t push_pkt, head_pkt;

  // Compare at CW+1 bits so a box ending near the top of the coordinate range cannot wrap.
  assign more_x   = ({1'b0, x_q} + XW'(LANES)) <= {1'b0, xmax_q};
  assign last_row = y_q == ymax_q;
  assign in_scan  = state_q == GEN_SCAN;
  assign skip     = SKIP_EMPTY && (span_mask == '0);
  assign push     = in_scan && !skip && !fifo_full;
  assign dispose  = in_scan && (skip || !fifo_full);

  assign push_pkt = '{x: x_q, y: y_q, mask: span_mask, w0: w_q[0], w1: w_q[1], w2: w_q[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GEN_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        GEN_IDLE: begin
          if (start) begin
            xmin_q <= xmin;
            xmax_q <= xmax;
            ymin_q <= ymin;
            ymax_q <= ymax;
            tl_q   <= tl;
            for (int i = 0; i < 3; i++) begin
              sx_q[i] <= sx_in[i];
              sy_q[i] <= sy_in[i];
              w_q[i]  <= w00_in[i];
              rb_q[i] <= w00_in[i];
            end
            if ((xmin > xmax) || (ymin > ymax)) done_q <= 1'b1;
            else state_q <= GEN_SETUP;
          end
        end
        GEN_SETUP: begin
          x_q <= xmin_q;
          y_q <= ymin_q;
          for (int i = 0; i < 3; i++) begin
            step_q[i] <= sx_q[i] << LG_LANES;
            for (int k = 0; k < LANES; k++) off_q[i][k] <= lane_mul(sx_q[i], 5'(k));
          end
          state_q <= GEN_SCAN;
        end
        GEN_SCAN: begin
          if (dispose) begin
            if (more_x) begin
              x_q <= x_q + CW'(LANES);
              for (int i = 0; i < 3; i++) w_q[i] <= w_q[i] + step_q[i];
            end else if (last_row) begin
              state_q <= GEN_IDLE;
              done_q  <= 1'b1;
            end else begin
              x_q <= xmin_q;
              y_q <= y_q + CW'(1);
              for (int i = 0; i < 3; i++) begin
                rb_q[i] <= rb_q[i] + sy_q[i];
                w_q[i]  <= rb_q[i] + sy_q[i];
              end
            end
          end
        end
        default: state_q <= GEN_IDLE;
      endcase
    end
  end

  span_fifo #(
    .WIDTH    ($bits(span_pkt_t)),
    .LG_DEPTH (LG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_pkt),
    .pop      (out_valid && out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_pkt)
  );

  assign out_valid = !fifo_empty;
  assign out_x     = head_pkt.x;
  assign out_y     = head_pkt.y;
  assign out_mask  = head_pkt.mask;
  assign out_w0    = head_pkt.w0;
  assign out_w1    = head_pkt.w1;
  assign out_w2    = head_pkt.w2;
  assign busy      = state_q != GEN_IDLE;
  assign done      = done_q;
  assign idle      = (state_q == GEN_IDLE) && fifo_empty;

endmodule

// File: tb/tb_raster_span_gen.sv
// Directed bench: u_a uses default parameters, u_b uses LG_DEPTH=2, SKIP_EMPTY=0, TOP_LEFT=0.
module tb_raster_span_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready;
  logic [15:0] xmin, xmax, ymin, ymax;
  logic [31:0] w0_00, w1_00, w2_00, sx0, sx1, sx2, sy0, sy1, sy2;
  logic [2:0]  tl;

  logic        a_valid, a_busy, a_done, a_idle, b_valid, b_busy, b_done, b_idle;
  logic [15:0] a_x, a_y, b_x, b_y;
  logic [3:0]  a_mask, b_mask;
  logic [31:0] a_w0, a_w1, a_w2, b_w0, b_w1, b_w2;

  raster_span_gen u_a (
    .clk(clk), .rst(rst), .start(start),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .w0_00(w0_00), .w1_00(w1_00), .w2_00(w2_00),
    .sx0(sx0), .sx1(sx1), .sx2(sx2), .sy0(sy0), .sy1(sy1), .sy2(sy2), .tl(tl),
    .out_valid(a_valid), .out_ready(out_ready), .out_x(a_x), .out_y(a_y), .out_mask(a_mask),
    .out_w0(a_w0), .out_w1(a_w1), .out_w2(a_w2),
    .busy(a_busy), .done(a_done), .idle(a_idle)
  );

  raster_span_gen #(.LG_DEPTH(2), .SKIP_EMPTY(1'b0), .TOP_LEFT(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .w0_00(w0_00), .w1_00(w1_00), .w2_00(w2_00),
    .sx0(sx0), .sx1(sx1), .sx2(sx2), .sy0(sy0), .sy1(sy1), .sy2(sy2), .tl(tl),
    .out_valid(b_valid), .out_ready(out_ready), .out_x(b_x), .out_y(b_y), .out_mask(b_mask),
    .out_w0(b_w0), .out_w1(b_w1), .out_w2(b_w2),
    .busy(b_busy), .done(b_done), .idle(b_idle)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  m;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } tpkt_t;

  function automatic tpkt_t mk(input logic [15:0] x, input logic [15:0] y, input logic [3:0] m,
                               input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    return '{x: x, y: y, m: m, w0: w0, w1: w1, w2: w2};
  endfunction

  tpkt_t qa[$];
  tpkt_t qb[$];
  int a_done_cnt = 0, b_done_cnt = 0, a_at_done = -1, b_at_done = -1;
  int a_d0, b_d0;
  int total = 0, bad = 0;

  // Collects popped packets and done pulses as seen at each rising edge.
  always @(posedge clk) begin
    if (a_done) begin
      a_done_cnt <= a_done_cnt + 1;
      a_at_done  <= qa.size();
    end
    if (b_done) begin
      b_done_cnt <= b_done_cnt + 1;
      b_at_done  <= qb.size();
    end
    if (!rst && out_ready && a_valid) qa.push_back(mk(a_x, a_y, a_mask, a_w0, a_w1, a_w2));
    if (!rst && out_ready && b_valid) qb.push_back(mk(b_x, b_y, b_mask, b_w0, b_w1, b_w2));
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_box(input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1);
    xmin = x0; xmax = x1; ymin = y0; ymax = y1;
  endtask

  task automatic set_edges(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] s0x, input logic [31:0] s1y, input logic [2:0] t);
    w0_00 = e0; w1_00 = e1; w2_00 = e2;
    sx0 = s0x; sx1 = 0; sx2 = 0;
    sy0 = 0; sy1 = s1y; sy2 = 0;
    tl = t;
  endtask

  task automatic prep();
    qa.delete();
    qb.delete();
    a_d0 = a_done_cnt;
    b_d0 = b_done_cnt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(a_idle && b_idle) && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, n < 300, 1'b1);
    tick(2);
  endtask

  task automatic run_tri(input string tag);
    prep();
    pulse_start();
    wait_idle(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    set_box(0, 0, 0, 0);
    set_edges(0, 0, 0, 0, 0, 3'b000);
    tick(2);
    check("reset_a", {a_valid, a_done, a_busy, a_idle}, 4'b0001);
    check("reset_b", {b_valid, b_done, b_busy, b_idle}, 4'b0001);
    rst = 1'b0;
    tick(1);

    // Two rows of a 6-wide box: full span then a 2-pixel tail span.
    set_box(0, 5, 0, 1);
    set_edges(1, 1, 1, 0, 0, 3'b111);
    out_ready = 1'b1;
    prep();
    pulse_start();
    check("t1_lat0", {a_busy, a_valid, b_valid}, 3'b100);
    tick(1);
    check("t1_lat1", {a_valid, b_valid}, 2'b00);
    tick(1);
    check("t1_lat2", {a_valid, b_valid}, 2'b11);
    check("t1_head", mk(a_x, a_y, a_mask, a_w0, a_w1, a_w2), mk(0, 0, 4'b1111, 1, 1, 1));
    wait_idle("t1_timeout");
    check("t1_cnt_a", qa.size(), 4);
    check("t1_cnt_b", qb.size(), 4);
    check("t1_p1", qa[1], mk(4, 0, 4'b0011, 1, 1, 1));
    check("t1_p2", qa[2], mk(0, 1, 4'b1111, 1, 1, 1));
    check("t1_p3", qa[3], mk(4, 1, 4'b0011, 1, 1, 1));
    check("t1_p3_b", qb[3], mk(4, 1, 4'b0011, 1, 1, 1));
    check("t1_done_a", a_done_cnt - a_d0, 1);
    check("t1_done_at", a_at_done, 3);

    // Lane values 2,1,0,-1 on edge 0 exercise the zero tie-break.
    set_box(0, 3, 0, 0);
    set_edges(2, 1, 1, 32'hFFFF_FFFF, 0, 3'b111);
    run_tri("t2a_timeout");
    check("t2_tl1_a", qa[0], mk(0, 0, 4'b0111, 2, 1, 1));
    check("t2_tl1_b", qb[0], mk(0, 0, 4'b0111, 2, 1, 1));
    set_edges(2, 1, 1, 32'hFFFF_FFFF, 0, 3'b110);
    run_tri("t2b_timeout");
    check("t2_tl0_a", qa[0], mk(0, 0, 4'b0011, 2, 1, 1));
    check("t2_tl0_b", qb[0], mk(0, 0, 4'b0111, 2, 1, 1));

    // Row step drives edge 1 negative on the second row.
    set_box(0, 3, 0, 1);
    set_edges(1, 2, 1, 0, 32'hFFFF_FFFD, 3'b111);
    run_tri("t3_timeout");
    check("t3_cnt_a", qa.size(), 1);
    check("t3_cnt_b", qb.size(), 2);
    check("t3_p0_a", qa[0], mk(0, 0, 4'b1111, 1, 2, 1));
    check("t3_p1_b", qb[1], mk(0, 1, 4'b0000, 1, 32'hFFFF_FFFF, 1));
    check("t3_done_a", a_done_cnt - a_d0, 1);

    // Backpressure: 8 full spans against a 4-deep FIFO on u_b.
    set_box(0, 15, 0, 1);
    set_edges(1, 1, 1, 0, 0, 3'b111);
    out_ready = 1'b0;
    prep();
    pulse_start();
    tick(20);
    check("t4_hold_b", {b_busy, b_valid}, 2'b11);
    check("t4_nodone_b", b_done_cnt - b_d0, 0);
    check("t4_done_a", a_done_cnt - a_d0, 1);
    check("t4_done_at_a", a_at_done, 0);
    out_ready = 1'b1;
    wait_idle("t4_timeout");
    check("t4_cnt_a", qa.size(), 8);
    check("t4_cnt_b", qb.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_ord_a%0d", i), qa[i], mk(16'(4 * (i % 4)), 16'(i / 4), 4'hF, 1, 1, 1));
      check($sformatf("t4_ord_b%0d", i), qb[i], mk(16'(4 * (i % 4)), 16'(i / 4), 4'hF, 1, 1, 1));
    end
    check("t4_done_b", b_done_cnt - b_d0, 1);
    check("t4_done_at_b", b_at_done, 5);

    // Empty box, then a start while busy that must be ignored.
    set_box(5, 3, 0, 0);
    prep();
    pulse_start();
    check("t5_empty0", {a_done, a_busy, a_valid, b_done, b_busy, b_valid}, 6'b100100);
    tick(1);
    check("t5_empty1", {a_done, b_done, a_valid, b_valid}, 4'b0000);
    tick(1);
    check("t5_done_a", a_done_cnt - a_d0, 1);
    check("t5_done_b", b_done_cnt - b_d0, 1);
    set_box(0, 7, 0, 0);
    prep();
    pulse_start();
    set_box(0, 3, 5, 5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("t5_timeout");
    check("t5_cnt_a", qa.size(), 2);
    check("t5_p1_a", qa[1], mk(4, 0, 4'b1111, 1, 1, 1));
    check("t5_cnt_b", qb.size(), 2);
    check("t5_done2_a", a_done_cnt - a_d0, 1);
    check("t5_quiet", {a_busy, b_busy}, 2'b00);

    // Reset with two packets queued, then a fresh triangle.
    set_box(0, 15, 0, 1);
    out_ready = 1'b0;
    prep();
    pulse_start();
    tick(3);
    check("t6_queued", {a_valid, b_valid}, 2'b11);
    rst = 1'b1;
    tick(1);
    check("t6_rst_a", {a_valid, a_idle, a_done, a_busy}, 4'b0100);
    check("t6_rst_b", {b_valid, b_idle, b_done, b_busy}, 4'b0100);
    rst = 1'b0;
    tick(3);
    check("t6_nodone", (a_done_cnt - a_d0) + (b_done_cnt - b_d0), 0);
    set_box(0, 5, 0, 1);
    out_ready = 1'b1;
    run_tri("t6_timeout");
    check("t6_first_a", qa[0], mk(0, 0, 4'b1111, 1, 1, 1));
    check("t6_first_b", qb[0], mk(0, 0, 4'b1111, 1, 1, 1));
    check("t6_cnt_a", qa.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
